esc_pwm_drv: RTL
================

ESC_PWM_DRV -- requirements
Module: esc_pwm_drv

Interface
REQ-001 Parameter PERIOD, default 125000: PWM period in clk cycles, legal range 16..2^20-1.
REQ-002 Parameter MIN_PW, default 6250: pulse width in cycles for speed 0.
REQ-003 Parameter ARM_PERIODS, default 16: count of MIN_PW-only periods emitted after the first vld.
REQ-004 Parameter WDOG_PERIODS, default 8: consecutive completed periods without vld that trip failsafe.
REQ-005 clk  in  1  system clock; one clock domain; all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 vld  in  1  single-cycle strobe qualifying the four speed inputs.
REQ-008 frnt_spd, bck_spd, lft_spd, rght_spd  in  11 each  unsigned motor speeds from the flight controller.
REQ-009 frnt_pwm, bck_pwm, lft_pwm, rght_pwm  out  1 each  registered ESC pulse outputs.
REQ-010 armed  out  1  high in states ARM, RUN and FAILSAFE.
REQ-011 wdog_trip  out  1  high while state is FAILSAFE.

Function
REQ-012 Period counter per_cnt: 20 bits, increments every cycle, wraps from PERIOD-1 to 0; the cycle with per_cnt==PERIOD-1 is the "boundary".
REQ-013 Shadow regs: on vld, all four speeds are captured together; the last vld before a boundary wins.
REQ-014 Active regs: at each boundary, active <= shadow; if vld is high in the boundary cycle, active <= the vld data directly.
REQ-015 Width per channel: pw = MIN_PW + 3*active_spd, computed at width >= 21 bits, then saturated to PERIOD-1.
REQ-016 Each pwm output is registered: pwm <= (per_cnt < pw_eff); the output is high exactly pw_eff consecutive cycles per period, starting the cycle after per_cnt==0.
REQ-017 pw_eff = 0 in IDLE; MIN_PW in ARM and FAILSAFE; pw from REQ-015 in RUN.
REQ-018 States are IDLE, ARM, RUN, FAILSAFE; all transitions occur only at a boundary edge, except reset.
REQ-019 IDLE -> ARM at the first boundary after any vld has been seen.
REQ-020 ARM -> RUN after ARM_PERIODS completed ARM periods; vld during ARM updates the shadow only.
REQ-021 Watchdog counter: cleared on any vld; otherwise increments at each boundary in RUN; saturates at WDOG_PERIODS.
REQ-022 RUN -> FAILSAFE at the boundary where the watchdog count reaches WDOG_PERIODS.
REQ-023 FAILSAFE -> RUN at the first boundary after a vld; that period uses the new speeds.
REQ-024 Simultaneous vld and watchdog-limit boundary: vld wins; no trip; state stays RUN.
REQ-025 Width changes never occur mid-period: no truncated or extended pulse is allowed.

Reset
REQ-026 rst high at a clock edge sets: per_cnt=0, state=IDLE, shadow=0, active=0, watchdog=0, all pwm=0, armed=0, wdog_trip=0.
REQ-027 rst asserted mid-pulse drops all pwm outputs low on the next edge; a prior vld is forgotten, and a new vld is required to re-arm.

Verification (PERIOD=100, MIN_PW=10, ARM_PERIODS=2, WDOG_PERIODS=3)
REQ-028 Reset, no vld for 500 cycles -> all pwm stay 0; armed=0.
REQ-029 vld with frnt=5, bck=0, lft=20, rght=2047 at per_cnt=40, then vld every 50 cycles -> armed at the next boundary; 2 periods of 10-cycle pulses on all outputs; then pulses of 25, 10, 70, 99 (saturated).
REQ-030 In RUN, vld with frnt=1 at per_cnt=30 while frnt pulse is high -> current pulse unchanged; 13-cycle pulse from the next period.
REQ-031 In RUN, vld stops -> 3 more full-speed periods, then wdog_trip=1 with 10-cycle pulses; one vld at per_cnt=50 -> the next period runs at the new speeds and wdog_trip=0.
REQ-032 vld coincident with per_cnt==99 in RUN (frnt=10) -> the following period's frnt pulse is 40 cycles.
REQ-033 rst pulsed at per_cnt=5 of a 70-cycle pulse -> pwm=0 on the next edge; state IDLE; no pulses until a new vld.

Source files
------------

// File: rtl/esc_pwm_drv.sv
// esc_pwm_drv
// Four-channel ESC pulse generator for a quadcopter. A free-running period
// counter defines the PWM frame. Speed commands arrive on a single-cycle
// strobe, are held in shadow registers and copied to the active registers
// only at the period boundary, so a pulse is never cut short or stretched.
// The arming sequence and watchdog failsafe are tracked by a small state
// machine.
//
// Ports
//   i_clk                       system clock, all state on the rising edge
//   i_rst                       synchronous active-high reset
//   i_vld                       strobe qualifying the four speed inputs
//   i_frnt/bck/lft/rght_spd     11-bit unsigned motor speeds
//   o_frnt/bck/lft/rght_pwm     registered ESC pulse outputs
//   o_armed                     high in ARM, RUN and FAILSAFE
//   o_wdog_trip                 high while in FAILSAFE
module esc_pwm_drv #(
  parameter int PERIOD       = 125000,
  parameter int MIN_PW       = 6250,
  parameter int ARM_PERIODS  = 16,
  parameter int WDOG_PERIODS = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic [10:0] i_frnt_spd,
  input  logic [10:0] i_bck_spd,
  input  logic [10:0] i_lft_spd,
  input  logic [10:0] i_rght_spd,
  output logic        o_frnt_pwm,
  output logic        o_bck_pwm,
  output logic        o_lft_pwm,
  output logic        o_rght_pwm,
  output logic        o_armed,
  output logic        o_wdog_trip
);

  localparam int AW      = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;
  localparam int WDW     = $clog2(WDOG_PERIODS + 1);
  localparam int MIN_SAT = (MIN_PW > PERIOD - 1) ? (PERIOD - 1) : MIN_PW;

  typedef enum logic [1:0] {IDLE, ARM, RUN, FAILSAFE} state_t;

  state_t          r_state;
  logic [19:0]     r_per_cnt;
  logic [10:0]     r_shadow [4];
  logic [10:0]     r_active [4];
  logic [WDW-1:0]  r_wdog;
  logic [AW-1:0]   r_arm_cnt;
  logic            r_seen;
  logic [3:0]      r_pwm;
  logic            r_armed;
  logic            r_wdog_trip;

  logic [10:0]     w_spd [4];
  logic [19:0]     w_pw_eff [4];
  logic            w_bnd;
  logic [WDW-1:0]  w_wdog_nxt;
  state_t          w_state_nxt;

  // Speed-to-width map; 22 bits keep MIN_PW + 3*2047 from overflowing
  // before the clamp to one cycle short of the full period.
  function automatic logic [19:0] runPw(input logic [10:0] spd);
    logic [21:0] raw;
    raw = 22'(MIN_PW) + 22'(spd) * 22'd3;
    if (raw > 22'(PERIOD - 1)) return 20'(PERIOD - 1);
    return raw[19:0];
  endfunction

  // Boundary detection, watchdog next value and next state. The next
  // watchdog value already includes a same-cycle vld, which is what lets
  // a vld on the limit boundary cancel the trip.
  always_comb begin
    w_spd[0] = i_frnt_spd;
    w_spd[1] = i_bck_spd;
    w_spd[2] = i_lft_spd;
    w_spd[3] = i_rght_spd;
    w_bnd = (r_per_cnt == 20'(PERIOD - 1));

    w_wdog_nxt = r_wdog;
    if (i_vld)
      w_wdog_nxt = '0;
    else if (w_bnd && r_state == RUN && r_wdog != WDW'(WDOG_PERIODS))
      w_wdog_nxt = r_wdog + WDW'(1);

    w_state_nxt = r_state;
    if (w_bnd) begin
      case (r_state)
        IDLE:     if (r_seen || i_vld) w_state_nxt = ARM;
        ARM:      if (r_arm_cnt == AW'(ARM_PERIODS - 1)) w_state_nxt = RUN;
        RUN:      if (w_wdog_nxt == WDW'(WDOG_PERIODS)) w_state_nxt = FAILSAFE;
        FAILSAFE: if (w_wdog_nxt != WDW'(WDOG_PERIODS)) w_state_nxt = RUN;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  // Effective width depends only on registers that change at the boundary,
  // so it is constant for a whole period.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      case (r_state)
        IDLE:    w_pw_eff[i] = '0;
        RUN:     w_pw_eff[i] = runPw(r_active[i]);
        default: w_pw_eff[i] = 20'(MIN_SAT);
      endcase
    end
  end

  // All sequential state. Outputs are registered from the next state so
  // armed/wdog_trip change on the same edge as the state itself.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_per_cnt   <= '0;
      r_wdog      <= '0;
      r_arm_cnt   <= '0;
      r_seen      <= 1'b0;
      r_pwm       <= '0;
      r_armed     <= 1'b0;
      r_wdog_trip <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_per_cnt <= w_bnd ? 20'd0 : r_per_cnt + 20'd1;
      if (i_vld) begin
        r_seen <= 1'b1;
        for (int i = 0; i < 4; i++) r_shadow[i] <= w_spd[i];
      end
      // vld on the boundary bypasses the shadow so it takes effect now.
      if (w_bnd) begin
        for (int i = 0; i < 4; i++)
          r_active[i] <= i_vld ? w_spd[i] : r_shadow[i];
      end
      if (r_state != ARM)
        r_arm_cnt <= '0;
      else if (w_bnd)
        r_arm_cnt <= r_arm_cnt + AW'(1);
      r_wdog      <= w_wdog_nxt;
      r_state     <= w_state_nxt;
      r_armed     <= (w_state_nxt != IDLE);
      r_wdog_trip <= (w_state_nxt == FAILSAFE);
      for (int i = 0; i < 4; i++)
        r_pwm[i] <= (r_per_cnt < w_pw_eff[i]);
    end
  end

  assign o_frnt_pwm  = r_pwm[0];
  assign o_bck_pwm   = r_pwm[1];
  assign o_lft_pwm   = r_pwm[2];
  assign o_rght_pwm  = r_pwm[3];
  assign o_armed     = r_armed;
  assign o_wdog_trip = r_wdog_trip;

endmodule
